prog_updown_counter: RTL

Parametrised successor to the team's basic up/down counter. Adds a programmable step, a programmable window [limit_lo, limit_hi], and a selectable wrap or saturate policy. A run-control FSM supports continuous or one-shot operation. Used as a general timer/event counter inside block-level testbench DUTs and small control paths.

---
 rtl/prog_updown_counter_if.sv | 43 ++++
 rtl/prog_updown_counter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/prog_updown_counter_if.sv
// Control/status bundle for prog_updown_counter; o_wrap_count exists only
// when CNT_WRAPCOUNT_EN is defined.
interface prog_updown_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              i_enable;
    logic              i_start;
    logic              i_stop;
    logic              i_load;
    logic [WIDTH-1:0]  i_load_data;
    logic              i_mode;
    logic [STEP_W-1:0] i_step;
    logic [WIDTH-1:0]  i_limit_lo;
    logic [WIDTH-1:0]  i_limit_hi;
    logic              i_sat;
    logic              i_oneshot;
    logic [WIDTH-1:0]  o_result;
    logic              o_tc;
    logic              o_busy;
    logic              o_done;
`ifdef CNT_WRAPCOUNT_EN
    logic [WIDTH-1:0]  o_wrap_count;
`endif

    modport master (
        output i_enable, i_start, i_stop, i_load, i_load_data, i_mode, i_step,
               i_limit_lo, i_limit_hi, i_sat, i_oneshot,
`ifdef CNT_WRAPCOUNT_EN
        input  o_wrap_count,
`endif
        input  o_result, o_tc, o_busy, o_done
    );

    modport slave (
        input  i_enable, i_start, i_stop, i_load, i_load_data, i_mode, i_step,
               i_limit_lo, i_limit_hi, i_sat, i_oneshot,
`ifdef CNT_WRAPCOUNT_EN
        output o_wrap_count,
`endif
        output o_result, o_tc, o_busy, o_done
    );
endinterface

// File: rtl/prog_updown_counter.sv
// Programmable up/down window counter with wrap/saturate policy and one-shot run FSM.
// Optional boundary-event counter output enabled by defining CNT_WRAPCOUNT_EN.
module prog_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input logic                clk,
    input logic                reset,
    prog_updown_counter_if.slave bus
);
    // One spare bit so up-count overflow and down-count underflow are visible.
    localparam int SUM_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_hi;
    logic [STEP_W-1:0] r_step;
    logic              r_mode;
    logic              r_sat;
    logic              r_oneshot;
    logic              r_tc;
    logic              r_busy;
    logic              r_done;

    logic [SUM_W-1:0]  w_res_ext;
    logic [SUM_W-1:0]  w_step_ext;
    logic [SUM_W-1:0]  w_up_sum;
    logic [SUM_W-1:0]  w_dn_diff;
    logic              w_up_evt;
    logic              w_dn_evt;
    logic              w_evt;
    logic              w_count;
    logic [WIDTH-1:0]  w_nxt;

    assign w_res_ext  = SUM_W'(r_result);
    assign w_step_ext = SUM_W'(r_step);
    assign w_up_sum   = w_res_ext + w_step_ext;
    assign w_dn_diff  = w_res_ext - w_step_ext;
    assign w_up_evt   = w_up_sum > SUM_W'(r_hi);
    assign w_dn_evt   = (w_res_ext < w_step_ext) || (w_dn_diff < SUM_W'(r_lo));
    assign w_evt      = r_mode ? w_dn_evt : w_up_evt;

    // A zero step or an inverted window makes counting a silent no-op.
    assign w_count = (r_state == ST_RUN) && bus.i_enable &&
                     (r_step != '0) && (r_lo <= r_hi);

    always_comb begin
        // NOTE: default first so every path assigns w_nxt and no latch is inferred.
        w_nxt = r_mode ? w_dn_diff[WIDTH-1:0] : w_up_sum[WIDTH-1:0];
        if (w_evt) begin
            // Up/wrap and down/sat land on lo; the other two land on hi.
            w_nxt = (r_sat ^ r_mode) ? r_hi : r_lo;
        end
    end

    // NOTE: non-blocking assignments keep all state updates in the same time step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_result  <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_step    <= '0;
            r_mode    <= 1'b0;
            r_sat     <= 1'b0;
            r_oneshot <= 1'b0;
            r_tc      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.i_stop) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (bus.i_start) begin
                r_lo      <= bus.i_limit_lo;
                r_hi      <= bus.i_limit_hi;
                r_step    <= bus.i_step;
                r_mode    <= bus.i_mode;
                r_sat     <= bus.i_sat;
                r_oneshot <= bus.i_oneshot;
                r_state   <= ST_RUN;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
            end else if (bus.i_load) begin
                r_result <= bus.i_load_data;
            end else if (w_count) begin
                r_result <= w_nxt;
                r_tc     <= w_evt;
                if (w_evt && r_oneshot) begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.o_result = r_result;
    assign bus.o_tc     = r_tc;
    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;

`ifdef CNT_WRAPCOUNT_EN
    logic [WIDTH-1:0] r_wrap_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrap_count <= '0;
        end else if (!bus.i_stop && bus.i_start) begin
            r_wrap_count <= '0;
        end else if (!bus.i_stop && !bus.i_load && w_count && w_evt &&
                     (r_wrap_count != '1)) begin
            r_wrap_count <= r_wrap_count + 1'b1;
        end
    end

    assign bus.o_wrap_count = r_wrap_count;
`else
    // Boundary-event counter is not built in this configuration.
`endif
endmodule
